// File: rtl/pri_enc_arb_if.sv
// Request/result bundle for pri_enc_arb: request side plus the valid/ready result channel.
// The arbiter connects as slave; whoever drives requests and consumes results connects as master.
interface pri_enc_arb_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         en;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         busy;

    modport master (
        output req, en, out_ready,
        input  out_valid, out_idx, out_onehot, busy
    );

    modport slave (
        input  req, en, out_ready,
        output out_valid, out_idx, out_onehot, busy
    );
endinterface

// File: rtl/pri_enc_arb.sv
// Registered N-input priority encoder with a valid/ready result channel.
// MODE=0 grants the highest set request bit; MODE=1 grants round-robin from a rotating pointer.
module pri_enc_arb #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    pri_enc_arb_if.slave  bus
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] oh_q, oh_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] ptr_after_hs;
    logic [W-1:0] search_ptr;
    logic [W-1:0] win_idx;
    logic         hs;
    logic         load;

    // The requester just served drops to lowest priority; its lower neighbour is searched first.
    assign ptr_after_hs = (idx_q == '0) ? LAST_IDX : idx_q - W'(1);

    assign hs         = (state == HOLD) && bus.out_ready;
    assign load       = bus.en && (|bus.req) && ((state == IDLE) || hs);
    assign search_ptr = hs ? ptr_after_hs : ptr_q;

    // Winner search. Indices are only ever formed from 0..N-1, so no index >= N can appear.
    always_comb begin : winner_search
        logic         found;
        logic [W-1:0] cand;
        int           pos;
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        pos     = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[W'(i)]) begin
                    win_idx = W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                pos = int'(search_ptr) - k;
                if (pos < 0) begin
                    pos = pos + N;
                end
                cand = W'(pos);
                if (!found && bus.req[cand]) begin
                    win_idx = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        idx_d      = idx_q;
        oh_d       = oh_q;
        ptr_d      = ptr_q;

        if (hs) begin
            ptr_d = ptr_after_hs;
        end

        case (state)
            IDLE: begin
                if (load) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    state_next = load ? HOLD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            idx_d = win_idx;
            oh_d  = {{(N-1){1'b0}}, 1'b1} << win_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx_q <= '0;
            oh_q  <= '0;
            ptr_q <= LAST_IDX;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_next;
            idx_q <= idx_d;
            oh_q  <= oh_d;
            ptr_q <= ptr_d;
        end
    end

    // out_valid comes straight from the state flop, so reset clears it without waiting for clk.
    assign bus.out_valid  = (state == HOLD);
    assign bus.busy       = (state == HOLD);
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = oh_q;

endmodule

// File: tb/tb_pri_enc_arb.sv
// Bench for pri_enc_arb: three instances (N=4 fixed, N=4 round-robin, N=5 round-robin)
// compared every cycle against a behavioural model of the grant rules.
module tb_pri_enc_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pri_enc_arb_if #(.N(4)) bus0 ();
    pri_enc_arb_if #(.N(4)) bus1 ();
    pri_enc_arb_if #(.N(5)) bus2 ();

    pri_enc_arb #(.N(4), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pri_enc_arb #(.N(4), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pri_enc_arb #(.N(5), .MODE(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [4:0] t_req [3];
    logic       t_en  [3];
    logic       t_rdy [3];

    assign bus0.req = t_req[0][3:0];
    assign bus1.req = t_req[1][3:0];
    assign bus2.req = t_req[2];
    assign bus0.en = t_en[0];
    assign bus1.en = t_en[1];
    assign bus2.en = t_en[2];
    assign bus0.out_ready = t_rdy[0];
    assign bus1.out_ready = t_rdy[1];
    assign bus2.out_ready = t_rdy[2];

    int m_n    [3] = '{4, 4, 5};
    int m_mode [3] = '{0, 1, 1};
    int m_valid[3];
    int m_idx  [3];
    int m_oh   [3];
    int m_ptr  [3];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Winner by rule: fixed = floor(log2(req)); RR = set bit at the smallest backward distance from ptr.
    function automatic int winner(int r, int p, int mode, int n);
        int best = -1;
        int bd   = n;
        if (mode == 0) return $clog2(r + 1) - 1;
        for (int i = 0; i < n; i++) begin
            if (((r >> i) & 1) == 1 && ((p - i + n) % n) < bd) begin
                bd   = (p - i + n) % n;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0;
            m_idx[d]   = 0;
            m_oh[d]    = 0;
            m_ptr[d]   = m_n[d] - 1;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int  r  = int'(t_req[d]) & ((1 << m_n[d]) - 1);
            bit  hs = (m_valid[d] == 1) && t_rdy[d];
            if (hs) m_ptr[d] = (m_idx[d] == 0) ? m_n[d] - 1 : m_idx[d] - 1;
            if (m_valid[d] == 0 || hs) begin
                if (t_en[d] && r != 0) begin
                    m_idx[d]   = winner(r, m_ptr[d], m_mode[d], m_n[d]);
                    m_oh[d]    = 1 << m_idx[d];
                    m_valid[d] = 1;
                end else begin
                    m_valid[d] = 0;
                end
            end
        end
    endtask

    task automatic check_dut(int d, logic v, logic [31:0] idx, logic [31:0] oh, logic b);
        string p = $sformatf("dut%0d", d);
        check({p, " out_valid"},  32'(v),   32'(m_valid[d]));
        check({p, " busy"},       32'(b),   32'(m_valid[d]));
        check({p, " out_idx"},    idx,      32'(m_idx[d]));
        check({p, " out_onehot"}, oh,       32'(m_oh[d]));
        check({p, " idx_range"},  32'(idx < 32'(m_n[d])), 32'd1);
    endtask

    task automatic check_all();
        check_dut(0, bus0.out_valid, 32'(bus0.out_idx), 32'(bus0.out_onehot), bus0.busy);
        check_dut(1, bus1.out_valid, 32'(bus1.out_idx), 32'(bus1.out_onehot), bus1.busy);
        check_dut(2, bus2.out_valid, 32'(bus2.out_idx), 32'(bus2.out_onehot), bus2.busy);
    endtask

    task automatic set_all(logic [4:0] r, logic e, logic y);
        for (int d = 0; d < 3; d++) begin
            t_req[d] = r;
            t_en[d]  = e;
            t_rdy[d] = y;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        set_all(5'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all();
        #1 rst = 1'b0;

        // Fixed-priority sweep over every 4-bit request pattern.
        for (int r = 0; r < 16; r++) begin
            set_all(5'(r), 1'b1, 1'b1);
            cycle();
        end
        set_all(5'd0, 1'b1, 1'b1);
        cycle();

        // Backpressure: result held while req changes underneath it.
        set_all(5'b01010, 1'b1, 1'b0);
        cycle();
        set_all(5'b00001, 1'b1, 1'b0);
        repeat (5) cycle();
        set_all(5'b00001, 1'b1, 1'b1);
        cycle();
        set_all(5'd0, 1'b1, 1'b1);
        cycle();

        // Round-robin fairness, skip/wrap, and N=5 wrap.
        set_all(5'b01111, 1'b1, 1'b1);
        repeat (6) cycle();
        set_all(5'b01001, 1'b1, 1'b1);
        repeat (4) cycle();
        set_all(5'b10001, 1'b1, 1'b1);
        repeat (4) cycle();

        // Reset between edges while holding; first grant afterwards starts from ptr=N-1.
        set_all(5'b01111, 1'b1, 1'b0);
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        set_all(5'b01111, 1'b1, 1'b0);
        cycle();

        // en=0 during HOLD: result still delivered, then back to IDLE.
        set_all(5'b01111, 1'b0, 1'b1);
        cycle();
        cycle();

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                t_req[d] = 5'($urandom_range(0, 31));
                t_en[d]  = ($urandom_range(0, 3) != 0);
                t_rdy[d] = ($urandom_range(0, 2) != 0);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
